// File: rtl/pipeline_skid_register.sv
// -----------------------------------------------------------------------------
// pipeline_skid_register
//
// Two-entry pipeline-stage register with valid/ready flow control. It sits
// between CPU pipeline stages (IF/ID/EX/MEM/WB). The main entry drives Q.
// The skid entry catches the one beat that can arrive in the cycle after
// downstream stalls. This lets InReady come from flops without losing
// throughput. All transfers are qualified by the global Tick, so the stage
// freezes together with the rest of the pipeline.
//
// Handshake: a beat moves across an interface on a rising Clock edge when
// valid, ready and Tick are all 1 in the cycle before that edge. The
// producer must hold valid and its payload until that happens. Ready may
// depend only on stage state plus Flush/Reset, never on the peer's valid.
//
// Parameters
//   NrOfBits    payload width
//   ResetValue  value loaded into both data entries on reset
//
// Ports
//   Clock      in   sole clock, rising edge
//   Reset      in   synchronous, active-high; priority over Flush and Tick
//   Tick       in   global clock-enable; no state change while 0 (except Reset)
//   Flush      in   synchronous squash; empties the stage on a ticked edge
//   InValid    in   upstream presents a beat on D
//   D          in   upstream payload
//   InReady    out  stage can accept a beat (Flush/Reset gate it combinationally)
//   OutValid   out  Q holds a valid beat
//   Q          out  head payload (main entry)
//   OutReady   in   downstream accepts the head beat
//   Occupancy  out  number of valid entries, 0..2
//   DbgState   out  raw FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module pipeline_skid_register #(
    parameter int unsigned          NrOfBits   = 32,
    parameter logic [NrOfBits-1:0]  ResetValue = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 Flush,
    input  logic                 InValid,
    input  logic [NrOfBits-1:0]  D,
    output logic                 InReady,
    output logic                 OutValid,
    output logic [NrOfBits-1:0]  Q,
    input  logic                 OutReady,
    output logic [1:0]           Occupancy,
    output logic [1:0]           DbgState
);

    // The state encoding equals the occupancy count. As a result, Occupancy
    // comes straight from the state flops, and OutValid is a single OR of them.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NrOfBits-1:0]  r_main;
    logic [NrOfBits-1:0]  r_skid;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_acc;
    logic                 w_rel;
    logic                 w_load_main_from_d;
    logic                 w_load_main_from_skid;
    logic                 w_load_skid_from_d;

    // Handshake qualifiers
    assign w_acc = InValid & w_in_ready & Tick;
    assign w_rel = w_out_valid & OutReady & Tick;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath load control
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state          = r_state;
        w_load_main_from_d    = 1'b0;
        w_load_main_from_skid = 1'b0;
        w_load_skid_from_d    = 1'b0;
        if (Tick) begin
            if (Flush) begin
                // Data entries are left as they are; only validity is dropped.
                w_next_state = ST_EMPTY;
            end else begin
                unique case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            w_next_state       = ST_ONE;
                            w_load_main_from_d = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && w_rel) begin
                            w_next_state       = ST_ONE;
                            w_load_main_from_d = 1'b1;
                        end else if (w_acc) begin
                            // Downstream stalled with a beat in flight: park it.
                            w_next_state       = ST_FULL;
                            w_load_skid_from_d = 1'b1;
                        end else if (w_rel) begin
                            w_next_state = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // InReady is low here, so acceptance cannot happen.
                        if (w_rel) begin
                            w_next_state          = ST_ONE;
                            w_load_main_from_skid = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state = ST_EMPTY;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // The flop-derived part of InReady depends on state alone. Flush and
        // Reset are gated in here, so a beat that the flush or reset is about
        // to discard never appears accepted to upstream.
        w_in_ready  = (r_state != ST_FULL) & ~Flush & ~Reset;
        w_out_valid = (r_state != ST_EMPTY);
    end

    assign InReady   = w_in_ready;
    assign OutValid  = w_out_valid;
    assign Occupancy = r_state;
    assign DbgState  = r_state;
    assign Q         = r_main;

    // ---------------------------------------------------------------------
    // Data entries
    // ---------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_main <= ResetValue;
            r_skid <= ResetValue;
        end else begin
            if (w_load_main_from_d) begin
                r_main <= D;
            end else if (w_load_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_from_d) begin
                r_skid <= D;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_skid_register.sv
module tb_pipeline_skid_register;

  localparam int W = 32;
  localparam logic [W-1:0] RST_VAL = 32'hDEAD_BEEF;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         Reset    = 1'b1;
  logic         Tick     = 1'b0;
  logic         Flush    = 1'b0;
  logic         InValid  = 1'b0;
  logic [W-1:0] D        = '0;
  logic         OutReady = 1'b0;
  logic         InReady;
  logic         OutValid;
  logic [W-1:0] Q;
  logic [1:0]   Occupancy;
  logic [1:0]   DbgState;

  pipeline_skid_register #(
    .NrOfBits   (W),
    .ResetValue (RST_VAL)
  ) dut (
    .Clock     (clk),
    .Reset     (Reset),
    .Tick      (Tick),
    .Flush     (Flush),
    .InValid   (InValid),
    .D         (D),
    .InReady   (InReady),
    .OutValid  (OutValid),
    .Q         (Q),
    .OutReady  (OutReady),
    .Occupancy (Occupancy),
    .DbgState  (DbgState)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // per-cycle observations from the driver
  logic         s_rel;
  logic [W-1:0] s_exp_q;
  logic [W-1:0] s_got_q;
  logic         s_exp_valid, s_got_valid;
  logic         s_exp_ready, s_got_ready;
  logic [1:0]   s_exp_occ, s_got_occ;

  // driver: applies one cycle of stimulus, samples the DUT mid-cycle and
  // updates the expected queue from the handshake the model predicts
  task automatic cycle(input logic rst, input logic tick, input logic flush,
                       input logic iv, input logic [W-1:0] d, input logic ordy);
    @(negedge clk);
    Reset = rst; Tick = tick; Flush = flush; InValid = iv; D = d; OutReady = ordy;
    #1;
    s_exp_valid = (exp_q.size() != 0);
    s_exp_occ   = 2'(exp_q.size());
    s_exp_ready = (exp_q.size() < 2) && !flush && !rst;
    s_got_valid = OutValid;
    s_got_ready = InReady;
    s_got_occ   = Occupancy;
    s_got_q     = Q;
    s_rel       = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else if (tick) begin
      if (s_exp_valid && ordy) begin
        s_rel   = 1'b1;
        s_exp_q = exp_q.pop_front();
      end
      if (flush) exp_q.delete();
      else if (iv && s_exp_ready) exp_q.push_back(d);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 1, 32'd55, 1);
    cycle(1, 1, 0, 1, 32'd55, 1);
    cycle(0, 0, 0, 0, 32'd0, 0);
    n_checks++; if (s_got_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", s_got_valid); end
    n_checks++; if (s_got_ready !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", s_got_ready); end
    n_checks++; if (s_got_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", s_got_occ); end
    n_checks++; if (s_got_q !== RST_VAL) begin n_fail++; $display("FAIL reset_q: got %h expected %h", s_got_q, RST_VAL); end
    // the beat offered during reset must not appear
    cycle(0, 1, 0, 0, 32'd0, 1);
    n_checks++; if (s_got_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got outvalid %b expected 0", s_got_valid); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 0, (i <= 4), W'(i), 1);
      n_checks++; if (s_got_ready !== 1'b1) begin n_fail++; $display("FAIL stream_inready: cycle %0d got %b expected 1", i, s_got_ready); end
      if (i >= 2) begin
        n_checks++; if (s_got_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occupancy: cycle %0d got %0d expected 1", i, s_got_occ); end
        n_checks++; if (!(s_rel && s_got_q === W'(i - 1))) begin n_fail++; $display("FAIL stream_q: cycle %0d got %0d (rel %b) expected %0d", i, s_got_q, s_rel, i - 1); end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] got[$];
    logic [W-1:0] want[3];
    want[0] = 32'd10; want[1] = 32'd11; want[2] = 32'd12;
    cycle(0, 1, 0, 1, 32'd10, 1);
    cycle(0, 1, 0, 1, 32'd11, 0);
    cycle(0, 1, 0, 1, 32'd12, 0);
    n_checks++; if (s_got_occ !== 2'd2) begin n_fail++; $display("FAIL stall_occupancy: got %0d expected 2", s_got_occ); end
    n_checks++; if (s_got_ready !== 1'b0) begin n_fail++; $display("FAIL stall_inready: got %b expected 0", s_got_ready); end
    n_checks++; if (s_got_q !== 32'd10) begin n_fail++; $display("FAIL stall_head: got %0d expected 10", s_got_q); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, (exp_q.size() < 3) && (got.size() < 2), 32'd12, 1);
      if (s_rel) begin
        n_checks++; if (s_got_q !== s_exp_q) begin n_fail++; $display("FAIL stall_sb: got %0d expected %0d", s_got_q, s_exp_q); end
        got.push_back(s_got_q);
      end
    end
    n_checks++;
    if (got.size() != 3 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2]) begin
      n_fail++; $display("FAIL stall_order: got %0d beats expected 10,11,12", got.size());
    end
    cycle(0, 1, 0, 0, 32'd0, 1);
  endtask

  task automatic test_tick_gating();
    cycle(0, 1, 0, 1, 32'd30, 0);
    cycle(0, 1, 0, 1, 32'd31, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 32'd32, 1);
      n_checks++; if (s_got_occ !== 2'd2) begin n_fail++; $display("FAIL tick_occupancy: cycle %0d got %0d expected 2", i, s_got_occ); end
      n_checks++; if (s_got_q !== 32'd30) begin n_fail++; $display("FAIL tick_q: cycle %0d got %0d expected 30", i, s_got_q); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 32'd0, 1);
      n_checks++; if (s_got_occ !== s_exp_occ) begin n_fail++; $display("FAIL tick_drain_occ: got %0d expected %0d", s_got_occ, s_exp_occ); end
      if (s_rel) begin
        n_checks++; if (s_got_q !== s_exp_q) begin n_fail++; $display("FAIL tick_drain_q: got %0d expected %0d", s_got_q, s_exp_q); end
      end
    end
  endtask

  task automatic test_flush();
    cycle(0, 1, 0, 1, 32'd20, 0);
    cycle(0, 1, 0, 1, 32'd21, 0);
    cycle(0, 1, 1, 1, 32'd22, 0);
    n_checks++; if (s_got_ready !== 1'b0) begin n_fail++; $display("FAIL flush_inready: got %b expected 0", s_got_ready); end
    cycle(0, 1, 0, 1, 32'd23, 1);
    n_checks++; if (s_got_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", s_got_occ); end
    n_checks++; if (s_got_valid !== 1'b0) begin n_fail++; $display("FAIL flush_outvalid: got %b expected 0", s_got_valid); end
    cycle(0, 1, 0, 0, 32'd0, 1);
    n_checks++; if (!(s_rel && s_got_q === 32'd23)) begin n_fail++; $display("FAIL flush_next_beat: got %0d (rel %b) expected 23", s_got_q, s_rel); end
  endtask

  task automatic test_random();
    logic [W-1:0] seq = 32'd1000;
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0), $urandom_range(0, 1), seq,
            ($urandom_range(0, 2) != 0));
      seq++;
      n_checks++;
      if (s_got_valid !== s_exp_valid || s_got_ready !== s_exp_ready ||
          s_got_occ !== s_exp_occ || s_got_occ > 2'd2) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_status: cycle %0d got v%b r%b o%0d expected v%b r%b o%0d",
                                i, s_got_valid, s_got_ready, s_got_occ, s_exp_valid, s_exp_ready, s_exp_occ);
      end
      if (s_rel) begin
        n_checks++;
        if (s_got_q !== s_exp_q) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_q: cycle %0d got %0d expected %0d", i, s_got_q, s_exp_q);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_tick_gating();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
